// File: rtl/backscatter_enc.sv
// -----------------------------------------------------------------------------
// backscatter_enc
//
// Tag-side baseband encoder. Takes the serial reply bit stream from the output
// controller and drives the backscatter modulator with FM0 or Miller-subcarrier
// (M = 2/4/8) symbols. Bit timing is counted in half-BLF ticks; the encoder
// also produces the one-cycle bit-rate strobe that paces the output controller.
//
// Handshake: the encoder is the timing master. o_datarate_ocu pulses on the
// last tick of every bit period. The controller presents the next bit on that
// edge, and the encoder samples it at the following tc==0 tick. There is no
// back-pressure.
//
// Ports:
//   clk             in   tag system clock
//   rst_n           in   asynchronous active-low reset
//   i_blf_tick      in   one-cycle pulse per half subcarrier period
//   i_m_dec[1:0]    in   00 FM0, 01 Miller M=2, 10 M=4, 11 M=8
//   i_clear_cu      in   synchronous abort; returns to IDLE with tc=0
//   i_enable_mod    in   reply bit stream active
//   i_data_ocu      in   current reply bit
//   i_mblf_mod      in   current bit is a Miller pilot bit (sent as data-0)
//   i_violate_mod   in   current bit carries the FM0 preamble violation
//   o_datarate_ocu  out  strobe on the last tick of each bit period
//   o_mod           out  modulator drive
//   o_busy          out  high while a reply is being encoded (FSM state)
// -----------------------------------------------------------------------------
module backscatter_enc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_blf_tick,
  input  logic [1:0] i_m_dec,
  input  logic       i_clear_cu,
  input  logic       i_enable_mod,
  input  logic       i_data_ocu,
  input  logic       i_mblf_mod,
  input  logic       i_violate_mod,
  output logic       o_datarate_ocu,
  output logic       o_mod,
  output logic       o_busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] tc_q, tc_d;
  logic [1:0] mreg_q, mreg_d;
  logic       bit_q, bit_d;
  logic       lvl_q, lvl_d;
  logic       b_q, b_d;
  logic       sc_q, sc_d;
  logic       prev_bit_q, prev_bit_d;

  logic [3:0] tc_last;
  logic [3:0] tc_half;
  logic       is_miller;
  logic       at_zero;
  logic       at_last;
  logic       at_half;
  logic       new_bit;

  // Period decode: T-1 and M (the mid-bit tick of a Miller symbol).
  always_comb begin
    tc_last   = 4'd1;
    tc_half   = 4'd0;
    is_miller = 1'b0;
    case (mreg_q)
      2'b00: begin tc_last = 4'd1;  tc_half = 4'd0; is_miller = 1'b0; end
      2'b01: begin tc_last = 4'd3;  tc_half = 4'd2; is_miller = 1'b1; end
      2'b10: begin tc_last = 4'd7;  tc_half = 4'd4; is_miller = 1'b1; end
      2'b11: begin tc_last = 4'd15; tc_half = 4'd8; is_miller = 1'b1; end
      default: begin tc_last = 4'd1; tc_half = 4'd0; is_miller = 1'b0; end
    endcase
  end

  assign at_zero = (tc_q == 4'd0);
  assign at_last = (tc_q == tc_last);
  assign at_half = (tc_q == tc_half);
  // Pilot bits are encoded as data-0.
  assign new_bit = i_data_ocu & ~i_mblf_mod;

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic. Both transitions happen only on a tc==0 tick.
  always_comb begin
    state_d = state_q;
    if (i_clear_cu) begin
      state_d = ST_IDLE;
    end else if (i_blf_tick && at_zero) begin
      state_d = i_enable_mod ? ST_ACTIVE : ST_IDLE;
    end
  end

  // FSM: outputs. The strobe is suppressed when an abort lands on the tick.
  always_comb begin
    o_datarate_ocu = i_blf_tick & ~i_clear_cu & at_last;
    o_busy         = (state_q == ST_ACTIVE);
    o_mod          = is_miller ? (b_q ^ sc_q) : lvl_q;
  end

  // Datapath next-state: tick counter, mode register and symbol generators.
  always_comb begin
    tc_d       = tc_q;
    mreg_d     = mreg_q;
    bit_d      = bit_q;
    lvl_d      = lvl_q;
    b_d        = b_q;
    sc_d       = sc_q;
    prev_bit_d = prev_bit_q;

    if (i_clear_cu) begin
      tc_d       = 4'd0;
      lvl_d      = 1'b0;
      b_d        = 1'b0;
      sc_d       = 1'b0;
      prev_bit_d = 1'b1;
    end else if (i_blf_tick) begin
      tc_d = at_last ? 4'd0 : tc_q + 4'd1;

      // Mode can only change between replies, on a bit boundary.
      if (state_q == ST_IDLE && at_zero) begin
        mreg_d = i_m_dec;
      end

      if (state_d == ST_ACTIVE) begin
        sc_d = ~sc_q;
        if (at_zero) begin
          // Bit boundary: decisions use the bit that is starting now. The
          // violation flag only matters here, so it is not stored.
          bit_d = new_bit;
          if (!i_violate_mod) begin
            lvl_d = ~lvl_q;
          end
          if (!new_bit && !prev_bit_q) begin
            b_d = ~b_q;
          end
          prev_bit_d = new_bit;
        end else begin
          if (tc_q == 4'd1 && !bit_q) begin
            lvl_d = ~lvl_q;
          end
          if (is_miller && at_half && bit_q) begin
            b_d = ~b_q;
          end
        end
      end else begin
        lvl_d      = 1'b0;
        b_d        = 1'b0;
        sc_d       = 1'b0;
        prev_bit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q       <= 4'd0;
      mreg_q     <= 2'b00;
      bit_q      <= 1'b0;
      lvl_q      <= 1'b0;
      b_q        <= 1'b0;
      sc_q       <= 1'b0;
      prev_bit_q <= 1'b1;
    end else begin
      tc_q       <= tc_d;
      mreg_q     <= mreg_d;
      bit_q      <= bit_d;
      lvl_q      <= lvl_d;
      b_q        <= b_d;
      sc_q       <= sc_d;
      prev_bit_q <= prev_bit_d;
    end
  end

endmodule

// File: tb/tb_backscatter_enc.sv
// -----------------------------------------------------------------------------
// tb_backscatter_enc
//
// Directed bench for backscatter_enc. Each scenario task drives its own
// stimulus and compares against hand-derived per-tick expectations.
// -----------------------------------------------------------------------------
module tb_backscatter_enc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_blf_tick = 1'b0;
  logic [1:0] i_m_dec = 2'b00;
  logic       i_clear_cu = 1'b0;
  logic       i_enable_mod = 1'b0;
  logic       i_data_ocu = 1'b0;
  logic       i_mblf_mod = 1'b0;
  logic       i_violate_mod = 1'b0;
  logic       o_datarate_ocu;
  logic       o_mod;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  backscatter_enc dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_blf_tick     (i_blf_tick),
    .i_m_dec        (i_m_dec),
    .i_clear_cu     (i_clear_cu),
    .i_enable_mod   (i_enable_mod),
    .i_data_ocu     (i_data_ocu),
    .i_mblf_mod     (i_mblf_mod),
    .i_violate_mod  (i_violate_mod),
    .o_datarate_ocu (o_datarate_ocu),
    .o_mod          (o_mod),
    .o_busy         (o_busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Driver: one tick, entered and left at posedge+1. Strobe is sampled while
  // the tick is high; o_mod/o_busy are sampled just after the tick edge.
  task automatic tick(output logic s, output logic m, output logic b);
    i_blf_tick = 1'b1;
    #1 s = o_datarate_ocu;
    @(posedge clk); #1;
    i_blf_tick = 1'b0;
    m = o_mod;
    b = o_busy;
    @(posedge clk); #1;
  endtask

  // Driver: abort, then play a whole reply acting as the output controller.
  // Records nbits*t+1 ticks (the last one is the exit tick).
  task automatic play_reply(input logic [1:0] mode, input int nbits, input int t,
                            input logic [7:0] bits, input logic mblf,
                            input logic [7:0] viol,
                            output logic [127:0] mods, output logic [127:0] strbs,
                            output logic [127:0] busys);
    logic s, m, b;
    int k;
    mods = '0; strbs = '0; busys = '0;
    i_m_dec = mode;
    i_clear_cu = 1'b1;
    @(posedge clk); #1;
    i_clear_cu = 1'b0;
    i_enable_mod = 1'b1;
    i_data_ocu = bits[0];
    i_mblf_mod = mblf;
    i_violate_mod = viol[0];
    for (int i = 0; i < nbits * t + 1; i++) begin
      tick(s, m, b);
      strbs[i] = s; mods[i] = m; busys[i] = b;
      if (i % t == t - 1) begin
        k = i / t + 1;
        if (k < nbits) begin
          i_data_ocu = bits[k];
          i_violate_mod = viol[k];
        end else begin
          i_enable_mod = 1'b0;
          i_data_ocu = 1'b0;
          i_violate_mod = 1'b0;
          i_mblf_mod = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic s, m, b;
    logic [0:3] e_strb;
    e_strb = 4'b0101;
    i_m_dec = 2'b00;
    i_enable_mod = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 3;
    if (o_mod !== 1'b0) begin errors++; $display("FAIL reset_mod_low: got %b expected 0", o_mod); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_low: got %b expected 0", o_busy); end
    if (o_datarate_ocu !== 1'b0) begin errors++; $display("FAIL reset_strobe_low: got %b expected 0", o_datarate_ocu); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (o_mod !== 1'b0) begin errors++; $display("FAIL reset_mod: got %b expected 0", o_mod); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    // Free-running counter in IDLE with T=2: strobe on every second tick.
    for (int i = 0; i < 4; i++) begin
      tick(s, m, b);
      checks += 3;
      if (s !== e_strb[i]) begin errors++; $display("FAIL idle_strobe tick %0d: got %b expected %b", i, s, e_strb[i]); end
      if (m !== 1'b0) begin errors++; $display("FAIL idle_mod tick %0d: got %b expected 0", i, m); end
      if (b !== 1'b0) begin errors++; $display("FAIL idle_busy tick %0d: got %b expected 0", i, b); end
    end
    checks++;
    if (o_datarate_ocu !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", o_datarate_ocu); end
  endtask

  task automatic test_fm0_data();
    logic [127:0] mods, strbs, busys;
    logic [0:8] e_mod;
    e_mod = 9'b110100110;
    play_reply(2'b00, 4, 2, 8'b00001101, 1'b0, 8'b0, mods, strbs, busys);
    for (int i = 0; i < 9; i++) begin
      checks += 3;
      if (mods[i] !== e_mod[i]) begin errors++; $display("FAIL fm0_mod tick %0d: got %b expected %b", i, mods[i], e_mod[i]); end
      if (strbs[i] !== (i % 2 == 1 && i < 8)) begin errors++; $display("FAIL fm0_strobe tick %0d: got %b expected %b", i, strbs[i], (i % 2 == 1 && i < 8)); end
      if (busys[i] !== (i < 8)) begin errors++; $display("FAIL fm0_busy tick %0d: got %b expected %b", i, busys[i], (i < 8)); end
    end
  endtask

  task automatic test_fm0_violation();
    logic [127:0] mods, strbs, busys;
    logic [0:12] e_mod;
    // Bits 1,0,1,0,1(violation),1: no inversion at the start of bit 5.
    e_mod = 13'b1101001000110;
    play_reply(2'b00, 6, 2, 8'b00110101, 1'b0, 8'b00010000, mods, strbs, busys);
    for (int i = 0; i < 13; i++) begin
      checks += 2;
      if (mods[i] !== e_mod[i]) begin errors++; $display("FAIL fm0_viol_mod tick %0d: got %b expected %b", i, mods[i], e_mod[i]); end
      if (busys[i] !== (i < 12)) begin errors++; $display("FAIL fm0_viol_busy tick %0d: got %b expected %b", i, busys[i], (i < 12)); end
    end
  endtask

  task automatic test_miller2();
    logic [127:0] mods, strbs, busys;
    logic [0:12] e_mod;
    // Bits 0,0,1: b flips at the 0->0 boundary and mid-way through the 1.
    e_mod = 13'b1010010101100;
    play_reply(2'b01, 3, 4, 8'b00000100, 1'b0, 8'b0, mods, strbs, busys);
    for (int i = 0; i < 13; i++) begin
      checks += 3;
      if (mods[i] !== e_mod[i]) begin errors++; $display("FAIL m2_mod tick %0d: got %b expected %b", i, mods[i], e_mod[i]); end
      if (strbs[i] !== (i % 4 == 3 && i < 12)) begin errors++; $display("FAIL m2_strobe tick %0d: got %b expected %b", i, strbs[i], (i % 4 == 3 && i < 12)); end
      if (busys[i] !== (i < 12)) begin errors++; $display("FAIL m2_busy tick %0d: got %b expected %b", i, busys[i], (i < 12)); end
    end
  endtask

  task automatic test_miller4_pilot();
    logic [127:0] mods, strbs, busys;
    logic e;
    // Four pilot bits with data=1, sent as data-0: b flips at every boundary
    // after the first, so odd bits show the inverted subcarrier.
    play_reply(2'b10, 4, 8, 8'b00001111, 1'b1, 8'b0, mods, strbs, busys);
    for (int i = 0; i < 33; i++) begin
      e = (i == 32) ? 1'b0 : (((i / 8) % 2 == 0) ? (i % 2 == 0) : (i % 2 == 1));
      checks += 2;
      if (mods[i] !== e) begin errors++; $display("FAIL m4_pilot_mod tick %0d: got %b expected %b", i, mods[i], e); end
      if (strbs[i] !== (i % 8 == 7 && i < 32)) begin errors++; $display("FAIL m4_pilot_strobe tick %0d: got %b expected %b", i, strbs[i], (i % 8 == 7 && i < 32)); end
    end
  endtask

  task automatic test_mode_change();
    logic s, m, b;
    logic [0:3] e_mod;
    logic [0:15] e_m8;
    e_mod = 4'b1100;
    e_m8 = 16'b1010101001010101;
    i_m_dec = 2'b00;
    i_clear_cu = 1'b1;
    @(posedge clk); #1;
    i_clear_cu = 1'b0;
    i_enable_mod = 1'b1;
    i_data_ocu = 1'b1;
    i_mblf_mod = 1'b0;
    i_violate_mod = 1'b0;
    // FM0 reply of bits 1,1 with the mode input switched to M=8 after entry.
    for (int i = 0; i < 4; i++) begin
      tick(s, m, b);
      if (i == 0) i_m_dec = 2'b11;
      if (i == 3) i_enable_mod = 1'b0;
      checks += 2;
      if (s !== (i % 2 == 1)) begin errors++; $display("FAIL mode_hold_strobe tick %0d: got %b expected %b", i, s, (i % 2 == 1)); end
      if (m !== e_mod[i]) begin errors++; $display("FAIL mode_hold_mod tick %0d: got %b expected %b", i, m, e_mod[i]); end
    end
    tick(s, m, b);
    checks += 2;
    if (m !== 1'b0) begin errors++; $display("FAIL mode_exit_mod: got %b expected 0", m); end
    if (b !== 1'b0) begin errors++; $display("FAIL mode_exit_busy: got %b expected 0", b); end
    // Next reply without abort: tc is 1 with T still 2, so one idle tick wraps.
    i_enable_mod = 1'b1;
    tick(s, m, b);
    checks += 2;
    if (s !== 1'b1) begin errors++; $display("FAIL mode_idle_wrap_strobe: got %b expected 1", s); end
    if (b !== 1'b0) begin errors++; $display("FAIL mode_idle_wrap_busy: got %b expected 0", b); end
    for (int i = 0; i < 16; i++) begin
      tick(s, m, b);
      if (i == 15) i_enable_mod = 1'b0;
      checks += 3;
      if (s !== (i == 15)) begin errors++; $display("FAIL m8_strobe tick %0d: got %b expected %b", i, s, (i == 15)); end
      if (m !== e_m8[i]) begin errors++; $display("FAIL m8_mod tick %0d: got %b expected %b", i, m, e_m8[i]); end
      if (b !== 1'b1) begin errors++; $display("FAIL m8_busy tick %0d: got %b expected 1", i, b); end
    end
    tick(s, m, b);
    checks += 2;
    if (m !== 1'b0) begin errors++; $display("FAIL m8_exit_mod: got %b expected 0", m); end
    if (b !== 1'b0) begin errors++; $display("FAIL m8_exit_busy: got %b expected 0", b); end
  endtask

  task automatic test_clear_and_reset();
    logic s, m, b;
    logic [0:2] e_mod;
    e_mod = 3'b101;
    i_m_dec = 2'b01;
    i_clear_cu = 1'b1;
    @(posedge clk); #1;
    i_clear_cu = 1'b0;
    i_enable_mod = 1'b1;
    i_data_ocu = 1'b0;
    i_mblf_mod = 1'b0;
    i_violate_mod = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(s, m, b);
      checks++;
      if (m !== e_mod[i]) begin errors++; $display("FAIL clr_pre_mod tick %0d: got %b expected %b", i, m, e_mod[i]); end
    end
    // Abort on the tick that would otherwise carry the strobe (tc=3).
    i_clear_cu = 1'b1;
    i_blf_tick = 1'b1;
    #1 s = o_datarate_ocu;
    @(posedge clk); #1;
    i_blf_tick = 1'b0;
    i_clear_cu = 1'b0;
    checks += 3;
    if (s !== 1'b0) begin errors++; $display("FAIL clr_strobe: got %b expected 0", s); end
    if (o_mod !== 1'b0) begin errors++; $display("FAIL clr_mod: got %b expected 0", o_mod); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", o_busy); end
    @(posedge clk); #1;
    // tc is 0 after the abort, so the very next tick starts a new reply.
    tick(s, m, b);
    checks += 3;
    if (s !== 1'b0) begin errors++; $display("FAIL clr_restart_strobe: got %b expected 0", s); end
    if (m !== 1'b1) begin errors++; $display("FAIL clr_restart_mod: got %b expected 1", m); end
    if (b !== 1'b1) begin errors++; $display("FAIL clr_restart_busy: got %b expected 1", b); end
    // Asynchronous reset away from the clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (o_mod !== 1'b0) begin errors++; $display("FAIL rst_async_mod: got %b expected 0", o_mod); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b expected 0", o_busy); end
    i_enable_mod = 1'b0;
    i_m_dec = 2'b00;
    @(posedge clk); #1;
    i_blf_tick = 1'b1;
    #1;
    checks++;
    if (o_datarate_ocu !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b expected 0", o_datarate_ocu); end
    @(posedge clk); #1;
    i_blf_tick = 1'b0;
    checks += 2;
    if (o_mod !== 1'b0) begin errors++; $display("FAIL rst_hold_mod: got %b expected 0", o_mod); end
    if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy: got %b expected 0", o_busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Counter restarts at 0 with T=2.
    tick(s, m, b);
    checks++;
    if (s !== 1'b0) begin errors++; $display("FAIL post_rst_tick0_strobe: got %b expected 0", s); end
    tick(s, m, b);
    checks += 2;
    if (s !== 1'b1) begin errors++; $display("FAIL post_rst_tick1_strobe: got %b expected 1", s); end
    if (m !== 1'b0) begin errors++; $display("FAIL post_rst_mod: got %b expected 0", m); end
  endtask

  initial begin
    test_reset();
    test_fm0_data();
    test_fm0_violation();
    test_miller2();
    test_miller4_pilot();
    test_mode_change();
    test_clear_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
